// File: rtl/opl3_pkg.sv
// Shared OPL3 types and constants: register-write bus and key-on LED fader definitions.
package opl3_pkg;

   typedef struct packed {
      logic       valid;
      logic       bank_num;
      logic [7:0] address;
      logic [7:0] data;
   } opl3_reg_wr_t;

   typedef enum logic [1:0] {
      OFF,
      ON,
      HOLD,
      DECAY
   } kon_led_state_e;

   localparam int unsigned KON_BIT       = 5;
   localparam logic [7:0]  KON_ADDR_BASE = 8'hB0;
   localparam int unsigned CH_PER_BANK   = 9;

   // Key-on register address of a channel within its bank.
   function automatic logic [7:0] kon_addr(input int unsigned ch);
      return KON_ADDR_BASE + 8'(ch % CH_PER_BANK);
   endfunction

endpackage

// File: rtl/opl3_kon_led_channel.sv
// One channel of the key-on LED fader: solid while keyed, held after key-off, then PWM fade-out.
module opl3_kon_led_channel
   import opl3_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES = 2400000,
   parameter int unsigned PWM_BITS    = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                hit_i,
   input  logic                kon_i,
   input  logic                decay_tick_i,
   input  logic [PWM_BITS-1:0] pwm_cnt_i,
   output logic                led_o
);

   localparam bit          HasHold = (HOLD_CYCLES > 0);
   localparam int unsigned HoldW   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HoldW-1:0] HoldInit = HoldW'(HasHold ? HOLD_CYCLES - 1 : 0);
   localparam logic [PWM_BITS-1:0] BrightMax = '1;

   kon_led_state_e      state_q, state_d;
   logic [HoldW-1:0]    hold_q, hold_d;
   logic [PWM_BITS-1:0] bright_q, bright_d;
   logic                led_q, led_d;

   always_comb begin
      state_d  = state_q;
      hold_d   = hold_q;
      bright_d = bright_q;
      // A key-on write wins over hold expiry and decay ticks in the same cycle.
      if (hit_i && kon_i) begin
         state_d  = ON;
         bright_d = BrightMax;
         hold_d   = '0;
      end else begin
         unique case (state_q)
            OFF: begin
            end
            ON: begin
               bright_d = BrightMax;
               if (hit_i) begin
                  if (HasHold) begin
                     state_d = HOLD;
                     hold_d  = HoldInit;
                  end else begin
                     state_d = DECAY;
                  end
               end
            end
            HOLD: begin
               if (hold_q == '0) begin
                  state_d  = DECAY;
                  bright_d = BrightMax;
               end else begin
                  hold_d = hold_q - 1'b1;
               end
            end
            DECAY: begin
               if (decay_tick_i) begin
                  if (bright_q <= PWM_BITS'(1)) begin
                     state_d  = OFF;
                     bright_d = '0;
                  end else begin
                     bright_d = bright_q - 1'b1;
                  end
               end
            end
            default: state_d = OFF;
         endcase
      end
   end

   // LED is registered from the next state so it moves together with the state.
   always_comb begin
      led_d = (state_d == ON) || (state_d == HOLD) ||
              ((state_d == DECAY) && (bright_d > pwm_cnt_i));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= OFF;
         hold_q   <= '0;
         bright_q <= '0;
         led_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         hold_q   <= hold_d;
         bright_q <= bright_d;
         led_q    <= led_d;
      end
   end

   assign led_o = led_q;

endmodule

// File: rtl/opl3_kon_led_fader.sv
// Key-on activity indicator: decodes KON register writes and drives one fading LED per channel.
module opl3_kon_led_fader
   import opl3_pkg::*;
#(
   parameter int unsigned NUM_CH      = 18,
   parameter int unsigned HOLD_CYCLES = 2400000,
   parameter int unsigned PWM_BITS    = 8,
   parameter int unsigned DECAY_DIV   = 48000
) (
   input  logic              clk,
   input  logic              reset,
   input  opl3_reg_wr_t      opl3_reg_wr,
   output logic [NUM_CH-1:0] led
);

   localparam int unsigned DivW = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
   localparam logic [DivW-1:0] DivLast = DivW'(DECAY_DIV - 1);

   logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
   logic [DivW-1:0]     div_q, div_d;
   logic                decay_tick;
   logic                kon;

   // Tick marks the cycle whose edge wraps the prescaler back to 0.
   assign decay_tick = (div_q == DivLast);
   assign kon        = opl3_reg_wr.data[KON_BIT];

   always_comb begin
      pwm_cnt_d = pwm_cnt_q + 1'b1;
      div_d     = decay_tick ? '0 : div_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pwm_cnt_q <= '0;
         div_q     <= '0;
      end else begin
         pwm_cnt_q <= pwm_cnt_d;
         div_q     <= div_d;
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic hit;

      assign hit = opl3_reg_wr.valid &&
                   (opl3_reg_wr.bank_num == 1'(i / CH_PER_BANK)) &&
                   (opl3_reg_wr.address == kon_addr(i));

      opl3_kon_led_channel #(
         .HOLD_CYCLES (HOLD_CYCLES),
         .PWM_BITS    (PWM_BITS)
      ) u_channel (
         .clk          (clk),
         .reset        (reset),
         .hit_i        (hit),
         .kon_i        (kon),
         .decay_tick_i (decay_tick),
         .pwm_cnt_i    (pwm_cnt_q),
         .led_o        (led[i])
      );
   end

endmodule

// File: tb/tb_opl3_kon_led_fader.sv
// Scoreboard bench for opl3_kon_led_fader: behavioural key/hold/fade model vs per-cycle LED output.
module tb_opl3_kon_led_fader;
   import opl3_pkg::*;

   localparam int NCH  = 18;
   localparam int HOLD = 4;
   localparam int PWMB = 3;
   localparam int DDIV = 2;
   localparam int MAXB = (1 << PWMB) - 1;

   logic            clk = 1'b0;
   logic            reset;
   opl3_reg_wr_t    wr;
   logic [NCH-1:0]  led;

   int checks = 0;
   int errors = 0;

   opl3_kon_led_fader #(
      .NUM_CH      (NCH),
      .HOLD_CYCLES (HOLD),
      .PWM_BITS    (PWMB),
      .DECAY_DIV   (DDIV)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .opl3_reg_wr (wr),
      .led         (led)
   );

   always #5 clk = ~clk;

   // Reference model: keyed flag, remaining solid cycles after release, fade level.
   bit             keyed     [NCH];
   int             hold_left [NCH];
   int             level     [NCH];
   int             cyc;
   logic [NCH-1:0] exp_q[$];

   task automatic model_step(input bit v, input bit b, input logic [7:0] a,
                             input logic [7:0] d, input bit r);
      logic [NCH-1:0] e;
      int pwm;
      bit tick, hit;
      e = '0;
      if (r) begin
         for (int i = 0; i < NCH; i++) begin
            keyed[i] = 0; hold_left[i] = 0; level[i] = 0;
         end
         cyc = 0;
      end else begin
         pwm  = cyc % (1 << PWMB);
         tick = (cyc % DDIV) == DDIV - 1;
         for (int i = 0; i < NCH; i++) begin
            hit = v && (b == (i / 9)) && (a == 8'hB0 + i % 9);
            if (hit && d[5]) begin
               keyed[i] = 1; hold_left[i] = 0; level[i] = MAXB;
            end else if (keyed[i]) begin
               if (hit) begin
                  keyed[i] = 0; hold_left[i] = HOLD; level[i] = MAXB;
               end
            end else if (hold_left[i] > 0) begin
               hold_left[i]--;
            end else if (tick && level[i] > 0) begin
               level[i]--;
            end
            e[i] = keyed[i] || hold_left[i] > 0 || level[i] > pwm;
         end
         cyc++;
      end
      exp_q.push_back(e);
   endtask

   task automatic step(input bit v, input bit b, input logic [7:0] a,
                       input logic [7:0] d, input bit r);
      wr.valid    = v;
      wr.bank_num = b;
      wr.address  = a;
      wr.data     = d;
      reset       = r;
      model_step(v, b, a, d, r);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, 0, 8'h00, 8'h00, 0);
   endtask

   task automatic key(input int ch, input bit on);
      step(1, ch >= 9, 8'(8'hB0 + ch % 9), on ? 8'h20 : 8'h00, 0);
   endtask

   // Monitor: the LED is presented every cycle, so one expectation is consumed per cycle.
   always @(negedge clk) begin
      logic [NCH-1:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (led !== e) begin
            errors++;
            $display("FAIL led at %0t: got %h expected %h", $time, led, e);
         end
      end
   end

   initial begin
      reset = 1'b1;
      wr    = '0;
      for (int k = 0; k < 3; k++) step(0, 0, 8'h00, 8'h00, 1);
      idle(100);
      // Unmapped address, then a full key-on / release / fade on channel 11.
      step(1, 0, 8'hB9, 8'h20, 0);
      idle(5);
      step(1, 1, 8'hB2, 8'h20, 0);
      idle(6);
      step(1, 1, 8'hB2, 8'h00, 0);
      idle(25);
      // Re-key during decay on channel 0, at both prescaler phases.
      for (int p = 0; p < 2; p++) begin
         key(0, 1); idle(3);
         key(0, 0); idle(HOLD + 8 + p);
         key(0, 1); idle(6);
         key(0, 0); idle(30);
      end
      // Second key-off during hold must not extend it.
      key(0, 1); idle(2);
      key(0, 0); idle(2);
      key(0, 0); idle(25);
      // All channels on back to back, release, reset mid-decay.
      for (int c = 0; c < NCH; c++) key(c, 1);
      idle(3);
      for (int c = 0; c < NCH; c++) key(c, 0);
      idle(HOLD + 3);
      step(0, 0, 8'h00, 8'h00, 1);
      idle(5);
      // Matching address with valid low.
      step(0, 0, 8'hB3, 8'h20, 0);
      idle(5);
      // Randomised traffic with occasional resets.
      for (int k = 0; k < 4000; k++) begin
         if ($urandom_range(0, 599) == 0) begin
            step(0, 0, 8'h00, 8'h00, 1);
         end else if ($urandom_range(0, 3) == 0) begin
            step($urandom_range(0, 4) != 0, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'(8'hB0 + $urandom_range(0, 9)),
                 8'($urandom), 0);
         end else begin
            idle(1);
         end
      end
      idle(2);
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
